// File: rtl/conv_filter_pkg.sv
// Shared types, pipeline depth and output-stage arithmetic for the 3x3 convolution filter.
package conv_filter_pkg;

  localparam int unsigned PIPE_LAT = 4;

  // Bit 3*row+col is set when that window tap lies inside the current frame.
  typedef logic [8:0] tap_mask_t;

  function automatic logic [31:0] shift_bias_clamp(
    input logic signed [31:0] sum,
    input logic        [3:0]  sh,
    input logic        [7:0]  bias,
    input int unsigned        dw
  );
    logic signed [31:0] v;
    logic signed [31:0] maxv;
    v    = (sum >>> sh) + $signed({24'd0, bias});
    maxv = (32'sd1 <<< dw) - 32'sd1;
    if (v < 0)         return '0;
    else if (v > maxv) return $unsigned(maxv);
    else               return $unsigned(v);
  endfunction

endpackage

// File: rtl/conv_filter_mc_core.sv
// One colour channel: line buffers, masked 3x3 window, multiply, adder tree, shift/bias/clamp.
module conv_ch_core
  import conv_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COEF_WIDTH = 5,
  parameter int unsigned MAX_WIDTH  = 2048
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic [$clog2(MAX_WIDTH)-1:0] addr_i,
  input  logic [8:0]                mask_i,
  input  logic [DATA_WIDTH-1:0]     pix_i,
  input  logic [9*COEF_WIDTH-1:0]   coef_i,
  input  logic                      v1_i,
  input  logic                      v2_i,
  input  logic                      v3_i,
  input  logic [3:0]                shift_i,
  input  logic [7:0]                bias_i,
  input  logic                      bypass_i,
  output logic [DATA_WIDTH-1:0]     data_o
);

  localparam int unsigned PW = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int unsigned SW = DATA_WIDTH + COEF_WIDTH + 5;

  logic [DATA_WIDTH-1:0]  lb_old_q [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]  lb_new_q [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]  cur      [3];
  logic [DATA_WIDTH-1:0]  col1_q   [3];
  logic [DATA_WIDTH-1:0]  col2_q   [3];
  logic [DATA_WIDTH-1:0]  win_q    [9];
  logic signed [PW-1:0]   prod_q   [9];
  logic signed [SW-1:0]   sum_d, sum_q;
  logic [DATA_WIDTH-1:0]  raw2_q, raw3_q;
  logic [DATA_WIDTH-1:0]  data_d, data_q;

  // Current column: two lines back, one line back, this pixel.
  always_comb begin
    cur[0] = lb_old_q[addr_i];
    cur[1] = lb_new_q[addr_i];
    cur[2] = pix_i;
  end

  always_ff @(posedge clk) begin
    if (valid_i) begin
      lb_old_q[addr_i] <= lb_new_q[addr_i];
      lb_new_q[addr_i] <= pix_i;
      for (int unsigned r = 0; r < 3; r++) begin
        win_q[3*r]   <= mask_i[3*r]   ? col2_q[r] : '0;
        win_q[3*r+1] <= mask_i[3*r+1] ? col1_q[r] : '0;
        win_q[3*r+2] <= mask_i[3*r+2] ? cur[r]    : '0;
        col2_q[r]    <= col1_q[r];
        col1_q[r]    <= cur[r];
      end
    end
    if (v1_i) begin
      for (int unsigned k = 0; k < 9; k++)
        prod_q[k] <= $signed(coef_i[k*COEF_WIDTH +: COEF_WIDTH]) * $signed({1'b0, win_q[k]});
      raw2_q <= win_q[8];
    end
    if (v2_i) begin
      sum_q  <= sum_d;
      raw3_q <= raw2_q;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < 9; k++)
      sum_d = sum_d + SW'(prod_q[k]);
  end

  always_comb begin
    data_d = DATA_WIDTH'(shift_bias_clamp(32'(sum_q), shift_i, bias_i, DATA_WIDTH));
    if (bypass_i)
      data_d = raw3_q;
  end

  always_ff @(posedge clk) begin
    if (reset)     data_q <= '0;
    else if (v3_i) data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/conv_filter_mc.sv
// Multi-channel 3x3 convolution filter: shared counters, per-frame shadows and sideband pipeline.
module conv_filter_mc
  import conv_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COEF_WIDTH = 5,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned MAX_WIDTH  = 2048
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    data_i,
  input  logic                            valid_i,
  input  logic                            sop_i,
  input  logic                            eop_i,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]  line_width_i,
  input  logic [9*COEF_WIDTH-1:0]         coef_i,
  input  logic [3:0]                      shift_i,
  input  logic [7:0]                      bias_i,
  input  logic                            bypass_i,
  output logic [NUM_CH*DATA_WIDTH-1:0]    data_o,
  output logic                            valid_o,
  output logic                            sop_o,
  output logic                            eop_o
);

  localparam int unsigned LWW = $clog2(MAX_WIDTH + 1);
  localparam int unsigned AW  = $clog2(MAX_WIDTH);

  logic [AW-1:0]           col_q, col_d, col_cur;
  logic [1:0]              row_q, row_d, row_cur;
  logic [LWW-1:0]          lw_q, lw_eff;
  logic [9*COEF_WIDTH-1:0] coef_q;
  logic [3:0]              shift_q, shift2_q, shift3_q;
  logic [7:0]              bias_q, bias2_q, bias3_q;
  logic                    bypass_q, bypass2_q, bypass3_q;
  logic [PIPE_LAT-1:0]     vld_q, sop_pipe_q, eop_pipe_q;
  tap_mask_t               win_mask;

  // A sop pixel uses its own config and position immediately, ahead of the shadow update.
  always_comb begin
    lw_eff  = sop_i ? line_width_i : lw_q;
    col_cur = sop_i ? '0 : col_q;
    row_cur = sop_i ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (valid_i) begin
      if (eop_i) begin
        col_d = '0;
        row_d = '0;
      end else if (LWW'(col_cur) == lw_eff - LWW'(1)) begin
        col_d = '0;
        row_d = (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
      end else begin
        col_d = col_cur + AW'(1);
        row_d = row_cur;
      end
    end
  end

  always_comb begin
    win_mask = '0;
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        win_mask[3*r+c] = (32'(row_cur) + r >= 2) && (32'(col_cur) + c >= 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      lw_q       <= LWW'(MAX_WIDTH);
      coef_q     <= '0;
      shift_q    <= '0;
      bias_q     <= '0;
      bypass_q   <= 1'b1;
      vld_q      <= '0;
      sop_pipe_q <= '0;
      eop_pipe_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (valid_i && sop_i) begin
        lw_q     <= line_width_i;
        coef_q   <= coef_i;
        shift_q  <= shift_i;
        bias_q   <= bias_i;
        bypass_q <= bypass_i;
      end
      vld_q      <= {vld_q[PIPE_LAT-2:0], valid_i};
      sop_pipe_q <= {sop_pipe_q[PIPE_LAT-2:0], valid_i & sop_i};
      eop_pipe_q <= {eop_pipe_q[PIPE_LAT-2:0], valid_i & eop_i};
    end
  end

  // Output-stage config follows its pixel so a back-to-back sop cannot disturb it.
  always_ff @(posedge clk) begin
    shift2_q  <= shift_q;
    bias2_q   <= bias_q;
    bypass2_q <= bypass_q;
    shift3_q  <= shift2_q;
    bias3_q   <= bias2_q;
    bypass3_q <= bypass2_q;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    conv_ch_core #(
      .DATA_WIDTH(DATA_WIDTH),
      .COEF_WIDTH(COEF_WIDTH),
      .MAX_WIDTH (MAX_WIDTH)
    ) u_core (
      .clk     (clk),
      .reset   (reset),
      .valid_i (valid_i),
      .addr_i  (col_cur),
      .mask_i  (win_mask),
      .pix_i   (data_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .coef_i  (coef_q),
      .v1_i    (vld_q[0]),
      .v2_i    (vld_q[1]),
      .v3_i    (vld_q[2]),
      .shift_i (shift3_q),
      .bias_i  (bias3_q),
      .bypass_i(bypass3_q),
      .data_o  (data_o[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign valid_o = vld_q[PIPE_LAT-1];
  assign sop_o   = sop_pipe_q[PIPE_LAT-1];
  assign eop_o   = eop_pipe_q[PIPE_LAT-1];

endmodule
